pipeline_mem_controller: RTL and testbench
==========================================

PIPELINE_MEM_CONTROLLER -- requirements
Module: pipeline_mem_controller

Interface
REQ-001 Parameter CNT_W, default 16, width of stall performance counter.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 id_rs1, id_rs2  in  5 each  source registers of instruction in IF/ID.
REQ-005 ex_rd  in  5  destination register of instruction in ID/EX.
REQ-006 ex_mem_read  in  1  instruction in ID/EX is a load.
REQ-007 ex_branch_taken  in  1  instruction in ID/EX is a resolved taken branch or jump.
REQ-008 mem_req  in  1  instruction in EX/MEM needs the shared memory (load/store).
REQ-009 mem_ready  in  1  shared memory completes the access of the currently selected requester this cycle.
REQ-010 mem_sel  out  1  memory port owner: 0 = instruction fetch, 1 = data access.
REQ-011 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register load enables.
REQ-012 if_id_flush, id_ex_flush  out  1 each  load a bubble (NOP) into that register when its enable is 1.
REQ-013 stall_cnt  out  CNT_W  count of cycles with pc_en=0 since reset.

Function
REQ-014 Two-state FSM: FETCH (mem_sel=0), DATA (mem_sel=1); mem_sel is a registered state decode.
REQ-015 Outputs other than mem_sel and stall_cnt are combinational from state and inputs.
REQ-016 FETCH, mem_req=1: next state DATA; all five enables 0, both flushes 0 (the in-flight fetch is discarded).
REQ-017 FETCH, mem_req=0, mem_ready=0: all enables 0; remain FETCH.
REQ-018 FETCH, mem_req=0, mem_ready=1, no hazard: all enables 1, flushes 0.
REQ-019 Load-use hazard = ex_mem_read and ex_rd != 0 and (ex_rd == id_rs1 or ex_rd == id_rs2).
REQ-020 Load-use on an advance cycle per REQ-018: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
REQ-021 Taken branch on an advance cycle: pc_en=1, if_id_en=1, id_ex_en=1, if_id_flush=1, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1; branch overrides load-use.
REQ-022 DATA, mem_ready=0: all enables 0; remain DATA.
REQ-023 DATA, mem_ready=1, no branch: pc_en=0, if_id_en=1 with if_id_flush=1, id_ex_en=1, ex_mem_en=1, mem_wb_en=1; next state FETCH.
REQ-024 DATA, mem_ready=1, ex_branch_taken=1: as REQ-023 plus pc_en=1 and id_ex_flush=1; next state FETCH.
REQ-025 Load-use is not evaluated in DATA (ID instruction moves to EX, IF/ID becomes bubble, so no dependent pair remains).
REQ-026 Data accesses have priority over fetch; mem_req is sampled only in FETCH.
REQ-027 stall_cnt increments by 1 on every cycle with pc_en=0, saturates at all-ones, never wraps.
REQ-028 Back-to-back data requests (mem_req=1 in first FETCH cycle after DATA) re-enter DATA; no forward progress of fetch is guaranteed by this block.

Reset
REQ-029 rst=1 at a rising edge: state FETCH, stall_cnt=0, regardless of state (including mid-DATA).
REQ-030 While rst=1: all enables 0, flushes 0, mem_sel=0; stall_cnt held at 0 (no increment).

Structure
REQ-031 Package pipeline_ctrl_pkg holds state encoding (FETCH=1'b0, DATA=1'b1) and the register-index width (5).
REQ-032 Load-use comparison in one combinational sub-module hazard_detect (inputs id_rs1, id_rs2, ex_rd, ex_mem_read; output load_use).
REQ-033 State register and stall counter are the only sequential elements.

Verification
REQ-034 FETCH, mem_ready=1, no hazards, 10 cycles -> all enables 1 each cycle, stall_cnt stays 0.
REQ-035 ex_mem_read=1, ex_rd=5, id_rs2=5, mem_ready=1 -> pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt +1; with ex_rd=0 -> no stall.
REQ-036 mem_req=1 in FETCH, then mem_ready=0 for 3 cycles then 1 -> mem_sel 1 for 4 cycles, enables 0 for 4 cycles, completion cycle gives if_id_flush=1, pc_en=0, then FETCH; stall_cnt=5.
REQ-037 ex_branch_taken=1 together with load-use in FETCH -> branch response (pc_en=1, both flushes 1), no stall.
REQ-038 rst=1 asserted in 2nd DATA cycle -> next cycle mem_sel=0, stall_cnt=0, all enables 0 while rst held.
REQ-039 Force stall_cnt near all-ones (CNT_W=4, 20 stall cycles) -> stall_cnt holds 15.

Source files
------------

// File: rtl/pipeline_mem_controller_pkg.sv
// Shared types for the pipeline memory-port controller: FSM state encoding and register-index width.
// No logic and no timing of its own.
package pipeline_ctrl_pkg;

   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] reg_idx_t;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } state_t;

endpackage

// File: rtl/pipeline_mem_controller_if.sv
// Pipeline-to-controller bundle: hazard inputs, memory handshake, register enables/flushes, stall count.
// The master side is the pipeline; the slave side is the controller.
interface pipeline_mem_controller_if #(parameter int CNT_W = 16);

   pipeline_ctrl_pkg::reg_idx_t id_rs1;
   pipeline_ctrl_pkg::reg_idx_t id_rs2;
   pipeline_ctrl_pkg::reg_idx_t ex_rd;
   logic             ex_mem_read;
   logic             ex_branch_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             mem_sel;
   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             mem_wb_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken, mem_req, mem_ready,
      input  mem_sel, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, stall_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken, mem_req, mem_ready,
      output mem_sel, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, stall_cnt
   );

endinterface

// File: rtl/pipeline_mem_controller_hazard_detect.sv
// Load-use detector: a load in ID/EX whose destination feeds either source of the IF/ID instruction.
// Purely combinational, zero latency; r0 never creates a hazard.
module hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  reg_idx_t id_rs1,
   input  reg_idx_t id_rs2,
   input  reg_idx_t ex_rd,
   input  logic     ex_mem_read,
   output logic     load_use
);

   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_mem_controller.sv
// Arbitrates one shared memory port between fetch and data access and steers pipeline enables/flushes.
// Enables respond combinationally; mem_ready=0 freezes every pipeline register until the access completes.
module pipeline_mem_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input logic                     clk,
   input logic                     rst,
   pipeline_mem_controller_if.slave bus
);

   state_t           state;
   logic             load_use;
   logic [CNT_W-1:0] stall_cnt;
   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             mem_wb_en;
   logic             if_id_flush;
   logic             id_ex_flush;

   hazard_detect u_hazard (
      .id_rs1      (bus.id_rs1),
      .id_rs2      (bus.id_rs2),
      .ex_rd       (bus.ex_rd),
      .ex_mem_read (bus.ex_mem_read),
      .load_use    (load_use)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         stall_cnt <= '0;
      end else begin
         if (state == FETCH) begin
            if (bus.mem_req) state <= DATA;
         end else begin
            if (bus.mem_ready) state <= FETCH;
         end
         if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
      end
   end

   always_comb begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (!rst) begin
         if (state == DATA) begin
            // Completing data access: the discarded fetch leaves a bubble in IF/ID.
            if (bus.mem_ready) begin
               pc_en       = bus.ex_branch_taken;
               if_id_en    = 1'b1;
               if_id_flush = 1'b1;
               id_ex_en    = 1'b1;
               id_ex_flush = bus.ex_branch_taken;
               ex_mem_en   = 1'b1;
               mem_wb_en   = 1'b1;
            end
         end else if (!bus.mem_req && bus.mem_ready) begin
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (bus.ex_branch_taken) begin
               pc_en       = 1'b1;
               if_id_en    = 1'b1;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (load_use) begin
               id_ex_flush = 1'b1;
            end else begin
               pc_en    = 1'b1;
               if_id_en = 1'b1;
            end
         end
      end
   end

   assign bus.mem_sel     = (state == DATA) && !rst;
   assign bus.pc_en       = pc_en;
   assign bus.if_id_en    = if_id_en;
   assign bus.id_ex_en    = id_ex_en;
   assign bus.ex_mem_en   = ex_mem_en;
   assign bus.mem_wb_en   = mem_wb_en;
   assign bus.if_id_flush = if_id_flush;
   assign bus.id_ex_flush = id_ex_flush;
   assign bus.stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_pipeline_mem_controller.sv
// Bench for pipeline_mem_controller: directed table, corner sequences and random traffic vs. a response model.
module tb_pipeline_mem_controller;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipeline_mem_controller_if #(.CNT_W(16)) b16 ();
   pipeline_mem_controller_if #(.CNT_W(4))  b4 ();

   assign b4.id_rs1          = b16.id_rs1;
   assign b4.id_rs2          = b16.id_rs2;
   assign b4.ex_rd           = b16.ex_rd;
   assign b4.ex_mem_read     = b16.ex_mem_read;
   assign b4.ex_branch_taken = b16.ex_branch_taken;
   assign b4.mem_req         = b16.mem_req;
   assign b4.mem_ready       = b16.mem_ready;

   pipeline_mem_controller #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
   pipeline_mem_controller #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));

   typedef struct {
      int         r, rs1, rs2, rd, lw, br, req, rdy;
      logic [7:0] o;
      int         s;
   } vec_t;

   vec_t tab [17];
   int checks = 0;
   int errors = 0;

   // Currently applied inputs and the reference model's view of the port owner and stall totals.
   int c_r, c_rs1, c_rs2, c_rd, c_lw, c_br, c_req, c_rdy;
   bit m_data = 1'b0;
   int m_stall = 0;
   int m_stall4 = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic drive(input int r, input int rs1, input int rs2, input int rd,
                        input int lw, input int br, input int req, input int rdy);
      c_r = r; c_rs1 = rs1; c_rs2 = rs2; c_rd = rd;
      c_lw = lw; c_br = br; c_req = req; c_rdy = rdy;
      rst                 = 1'(r);
      b16.id_rs1          = 5'(rs1);
      b16.id_rs2          = 5'(rs2);
      b16.ex_rd           = 5'(rd);
      b16.ex_mem_read     = 1'(lw);
      b16.ex_branch_taken = 1'(br);
      b16.mem_req         = 1'(req);
      b16.mem_ready       = 1'(rdy);
   endtask

   // Response code {pc,if_id,id_ex,ex_mem,mem_wb,if_id_flush,id_ex_flush,mem_sel} for the applied inputs.
   function automatic logic [7:0] model_out();
      bit hz;
      hz = (c_lw != 0) && (c_rd != 0) && (c_rd == c_rs1 || c_rd == c_rs2);
      if (c_r != 0) return 8'h00;
      if (m_data) return (c_rdy == 0) ? 8'h01 : ((c_br != 0) ? 8'hFF : 8'h7D);
      if (c_req != 0 || c_rdy == 0) return 8'h00;
      if (c_br != 0) return 8'hFE;
      if (hz) return 8'h3A;
      return 8'hF8;
   endfunction

   function automatic logic [7:0] dut_out();
      return {b16.pc_en, b16.if_id_en, b16.id_ex_en, b16.ex_mem_en, b16.mem_wb_en,
              b16.if_id_flush, b16.id_ex_flush, b16.mem_sel};
   endfunction

   task automatic tick(input string nm, input bit has_tab, input logic [7:0] tab_o, input int tab_s);
      logic [7:0] exp_o;
      @(negedge clk);
      exp_o = model_out();
      chk({nm, " out"}, 32'(dut_out()), 32'(exp_o));
      chk({nm, " stall16"}, 32'(b16.stall_cnt), 32'(m_stall));
      chk({nm, " stall4"}, 32'(b4.stall_cnt), 32'(m_stall4));
      if (has_tab) begin
         chk({nm, " tab_out"}, 32'(dut_out()), 32'(tab_o));
         chk({nm, " tab_stall"}, 32'(b16.stall_cnt), 32'(tab_s));
      end
      @(posedge clk);
      if (c_r != 0) begin
         m_data = 1'b0; m_stall = 0; m_stall4 = 0;
      end else begin
         if (exp_o[7] == 1'b0) begin
            m_stall  = (m_stall  < 65535) ? m_stall + 1  : 65535;
            m_stall4 = (m_stall4 < 15)    ? m_stall4 + 1 : 15;
         end
         m_data = m_data ? (c_rdy == 0) : (c_req != 0);
      end
      #1;
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      tick("reset0", 1'b0, 8'h00, 0);
      tick("reset1", 1'b0, 8'h00, 0);
   endtask

   initial begin
      tab[0]  = '{1, 0, 0, 0, 0, 0, 0, 1, 8'h00, 0};
      tab[1]  = '{1, 0, 0, 0, 0, 0, 1, 1, 8'h00, 0};
      tab[2]  = '{0, 1, 2, 3, 0, 0, 0, 1, 8'hF8, 0};
      tab[3]  = '{0, 3, 5, 5, 1, 0, 0, 1, 8'h3A, 0};
      tab[4]  = '{0, 0, 0, 0, 1, 0, 0, 1, 8'hF8, 1};
      tab[5]  = '{0, 7, 1, 7, 1, 1, 0, 1, 8'hFE, 1};
      tab[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1};
      tab[7]  = '{0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 2};
      tab[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h01, 3};
      tab[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h01, 4};
      tab[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h01, 5};
      tab[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 8'h7D, 6};
      tab[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 8'h00, 7};
      tab[13] = '{0, 4, 0, 4, 1, 1, 0, 1, 8'hFF, 8};
      tab[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 8'hF8, 8};
      tab[15] = '{1, 0, 0, 0, 0, 0, 1, 1, 8'h00, 8};
      tab[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 8'hF8, 0};

      drive(1, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         drive(tab[i].r, tab[i].rs1, tab[i].rs2, tab[i].rd,
               tab[i].lw, tab[i].br, tab[i].req, tab[i].rdy);
         tick($sformatf("vec%0d", i), 1'b1, tab[i].o, tab[i].s);
      end

      // Ten plain advance cycles never stall.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(0, 1, 2, 3, 0, 0, 0, 1);
         tick($sformatf("adv%0d", i), 1'b1, 8'hF8, 0);
      end
      chk("adv stall_cnt", 32'(b16.stall_cnt), 32'd0);

      // Data request, three wait cycles, completion.
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      tick("dreq", 1'b1, 8'h00, 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0);
         tick($sformatf("dwait%0d", i), 1'b1, 8'h01, i + 1);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      tick("ddone", 1'b1, 8'h7D, 4);
      chk("ddone mem_sel", 32'(b16.mem_sel), 32'd0);
      chk("ddone stall_cnt", 32'(b16.stall_cnt), 32'd5);

      // Reset arriving in the second DATA cycle.
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 1, 1);
      tick("rdreq", 1'b0, 8'h00, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick("rdata1", 1'b1, 8'h01, 1);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      tick("rdata2", 1'b1, 8'h00, 2);
      chk("rst mem_sel", 32'(b16.mem_sel), 32'd0);
      chk("rst stall_cnt", 32'(b16.stall_cnt), 32'd0);
      chk("rst enables", 32'(dut_out()), 32'd0);
      tick("rhold", 1'b1, 8'h00, 0);

      // Saturation of the narrow counter.
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) tick($sformatf("sat%0d", i), 1'b0, 8'h00, 0);
      chk("sat stall4", 32'(b4.stall_cnt), 32'd15);
      chk("sat stall16", 32'(b16.stall_cnt), 32'd20);

      // Random traffic with small register indices so hazards are frequent.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         drive(($urandom_range(63, 0) == 0) ? 1 : 0,
               int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
               ($urandom_range(2, 0) == 0) ? 1 : 0, ($urandom_range(3, 0) == 0) ? 1 : 0,
               ($urandom_range(3, 0) == 0) ? 1 : 0, ($urandom_range(1, 0) == 0) ? 1 : 0);
         tick($sformatf("rnd%0d", i), 1'b0, 8'h00, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
